hx8352_bus_arbiter: RTL and testbench

- Shares the single HX8352 LCD bus writer between two requesters: port 0 (init sequencer) and port 1 (pixel/draw engine).
- Grants the bus to one port, forwards its command/data words one at a time, and returns per-word completion.
- Owns the LCD chip-select, including hold-off between grants.
- Runs a bus watchdog; a hung bus writer cannot deadlock either requester.

---
 rtl/hx8352_pkg.sv | 17 +
 rtl/hx8352_cs_hold.sv | 44 ++++
 rtl/hx8352_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_hx8352_bus_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hx8352_pkg.sv
// Shared constants and arbiter state encoding for the HX8352 LCD bus arbiter.
package hx8352_pkg;

    localparam logic LCD_CMD   = 1'b0;
    localparam logic LCD_DATA  = 1'b1;

    localparam logic PORT_INIT = 1'b0;
    localparam logic PORT_DRAW = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANTED  = 2'd1,
        ST_ISSUE    = 2'd2,
        ST_WAIT_BUS = 2'd3
    } arb_state_e;

endpackage

// File: rtl/hx8352_cs_hold.sv
// Drives the active-low LCD chip select: low while any port is granted,
// held low for CS_HOLD cycles after the grant ends, then released.
module hx8352_cs_hold #(
    parameter int CS_HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic gnt_any,
    output logic lcd_cs
);

    localparam int CNT_W = (CS_HOLD < 1) ? 1 : $clog2(CS_HOLD + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cs_q, cs_d;

    // gnt_any is the arbiter's next-state grant, so chip select moves on the same edge as gnt.
    always_comb begin
        cnt_d = cnt_q;
        cs_d  = cs_q;
        if (gnt_any) begin
            cnt_d = CNT_W'(CS_HOLD);
            cs_d  = 1'b0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            cs_d  = 1'b0;
        end else begin
            cs_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            cs_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            cs_q  <= cs_d;
        end
    end

    assign lcd_cs = cs_q;

endmodule

// File: rtl/hx8352_bus_arbiter.sv
// Two-port arbiter in front of the HX8352 bus writer. Handshake: a port owns the
// bus while its gnt is high; each step strobe hands over one word, and the port
// must wait for its done pulse before stepping again. dbg_state exposes the FSM.
module hx8352_bus_arbiter
    import hx8352_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CS_HOLD        = 4,
    parameter int ROUND_ROBIN    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic        r0_lock,
    input  logic        r0_step,
    input  logic        r0_cod,
    input  logic [15:0] r0_data,
    output logic        r0_gnt,
    output logic        r0_done,
    input  logic        r1_req,
    input  logic        r1_lock,
    input  logic        r1_step,
    input  logic        r1_cod,
    input  logic [15:0] r1_data,
    output logic        r1_gnt,
    output logic        r1_done,
    output logic        bus_step,
    output logic        bus_cod,
    output logic [15:0] bus_data,
    input  logic        bus_done,
    output logic        lcd_cs,
    output logic        busy,
    output logic        timeout_err,
    output logic [1:0]  dbg_state
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic             cod_q, cod_d;
    logic [15:0]      data_q, data_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic own_req, own_lock, own_step, own_cod;
    logic [15:0] own_data;

    assign own_req  = (owner_q == PORT_DRAW) ? r1_req  : r0_req;
    assign own_lock = (owner_q == PORT_DRAW) ? r1_lock : r0_lock;
    assign own_step = (owner_q == PORT_DRAW) ? r1_step : r0_step;
    assign own_cod  = (owner_q == PORT_DRAW) ? r1_cod  : r0_cod;
    assign own_data = (owner_q == PORT_DRAW) ? r1_data : r0_data;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cod_d   = cod_q;
        data_d  = data_q;
        wd_d    = wd_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (r0_req || r1_req) begin
                    if (r0_req && r1_req) begin
                        owner_d = (ROUND_ROBIN != 0) ? ~last_q : PORT_INIT;
                    end else begin
                        owner_d = r1_req ? PORT_DRAW : PORT_INIT;
                    end
                    last_d  = owner_d;
                    state_d = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                if (own_step) begin
                    cod_d   = own_cod;
                    data_d  = own_data;
                    state_d = ST_ISSUE;
                end else if (!own_req && !own_lock) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_WAIT_BUS;
            end
            ST_WAIT_BUS: begin
                // A bus_done arriving on the terminal count still completes the word cleanly.
                if (bus_done) begin
                    done_d  = 1'b1;
                    state_d = ST_GRANTED;
                end else begin
                    if (wd_q != WD_MAX) wd_d = wd_q + WD_W'(1);
                    if (wd_q >= WD_LAST) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= PORT_INIT;
            last_q  <= PORT_DRAW;
            cod_q   <= LCD_CMD;
            data_q  <= '0;
            wd_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cod_q   <= cod_d;
            data_q  <= data_d;
            wd_q    <= wd_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    hx8352_cs_hold #(.CS_HOLD(CS_HOLD)) u_cs_hold (
        .clk     (clk),
        .rst     (rst),
        .gnt_any (state_d != ST_IDLE),
        .lcd_cs  (lcd_cs)
    );

    assign busy        = (state_q != ST_IDLE);
    assign r0_gnt      = busy && (owner_q == PORT_INIT);
    assign r1_gnt      = busy && (owner_q == PORT_DRAW);
    assign r0_done     = done_q && (owner_q == PORT_INIT);
    assign r1_done     = done_q && (owner_q == PORT_DRAW);
    assign bus_step    = (state_q == ST_ISSUE);
    assign bus_cod     = cod_q;
    assign bus_data    = data_q;
    assign timeout_err = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_hx8352_bus_arbiter.sv
// Bench for hx8352_bus_arbiter: two instances (fixed priority and round robin)
// share one stimulus stream and are checked against a transaction-level model.
module tb_hx8352_bus_arbiter;
    import hx8352_pkg::*;

    localparam int TO  = 8;
    localparam int CSH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req = 0, r0_lock = 0, r0_step = 0, r0_cod = 0;
    logic [15:0] r0_data = '0;
    logic        r1_req = 0, r1_lock = 0, r1_step = 0, r1_cod = 0;
    logic [15:0] r1_data = '0;
    logic        bus_done = 0;

    logic [1:0]  r0_gnt, r0_done, r1_gnt, r1_done, bus_step, bus_cod, lcd_cs, busy, timeout_err;
    logic [15:0] bus_data [2];
    logic [1:0]  dbg_state [2];

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];
    logic        exp_last [2];
    logic [1:0]  prev_g [2];
    logic [1:0]  mon_cur;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        hx8352_bus_arbiter #(.TIMEOUT_CYCLES(TO), .CS_HOLD(CSH), .ROUND_ROBIN(g)) dut (
            .clk(clk), .rst(rst),
            .r0_req(r0_req), .r0_lock(r0_lock), .r0_step(r0_step), .r0_cod(r0_cod), .r0_data(r0_data),
            .r0_gnt(r0_gnt[g]), .r0_done(r0_done[g]),
            .r1_req(r1_req), .r1_lock(r1_lock), .r1_step(r1_step), .r1_cod(r1_cod), .r1_data(r1_data),
            .r1_gnt(r1_gnt[g]), .r1_done(r1_done[g]),
            .bus_step(bus_step[g]), .bus_cod(bus_cod[g]), .bus_data(bus_data[g]), .bus_done(bus_done),
            .lcd_cs(lcd_cs[g]), .busy(busy[g]), .timeout_err(timeout_err[g]), .dbg_state(dbg_state[g])
        );
    end

    always #5 clk = ~clk;

    // Protocol invariants: never two grants, never a direct port-to-port handover, cs low while granted.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            mon_cur = {r1_gnt[d], r0_gnt[d]};
            if (rst) begin
                checks++;
                if ((mon_cur | prev_g[d]) == 2'b11 || (mon_cur != 2'b00 && lcd_cs[d] !== 1'b0)) begin
                    errors++;
                    $display("FAIL monitor dut%0d: gnt=%b prev=%b cs=%b, required no overlap/direct switch and cs=0 while granted",
                             d, mon_cur, prev_g[d], lcd_cs[d]);
                end
            end
            prev_g[d] = rst ? mon_cur : 2'b00;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration rule.
    function automatic logic pick(input logic q0, input logic q1, input int rr, input logic last);
        if (q0 && q1) return (rr != 0) ? ~last : 1'b0;
        return q1;
    endfunction

    function automatic logic done_of(input int d, input int p);
        return (p == 0) ? r0_done[d] : r1_done[d];
    endfunction

    function automatic logic gnt_of(input int d, input int p);
        return (p == 0) ? r0_gnt[d] : r1_gnt[d];
    endfunction

    task automatic set_step(input int p, input logic v, input logic cod, input logic [15:0] data);
        if (p == 0) begin r0_step = v; r0_cod = cod; r0_data = data; end
        else        begin r1_step = v; r1_cod = cod; r1_data = data; end
    endtask

    task automatic acquire(input int p);
        if (p == 0) r0_req = 1'b1; else r1_req = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            exp_last[d] = (p != 0);
            checks++;
            if (gnt_of(d, p) !== 1'b1 || gnt_of(d, 1 - p) !== 1'b0 || lcd_cs[d] !== 1'b0 || busy[d] !== 1'b1) begin
                errors++;
                $display("FAIL acquire dut%0d p%0d: gnt=%b%b cs=%b busy=%b, required owner gnt=1 cs=0 busy=1",
                         d, p, r1_gnt[d], r0_gnt[d], lcd_cs[d], busy[d]);
            end
        end
    endtask

    task automatic release_port(input int p);
        if (p == 0) begin r0_req = 1'b0; r0_lock = 1'b0; end
        else        begin r1_req = 1'b0; r1_lock = 1'b0; end
        tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (r0_gnt[d] !== 1'b0 || r1_gnt[d] !== 1'b0 || busy[d] !== 1'b0) begin
                errors++;
                $display("FAIL release_gnt dut%0d: gnt=%b%b busy=%b, required 00 0", d, r1_gnt[d], r0_gnt[d], busy[d]);
            end
        end
        for (int k = 0; k <= CSH; k++) begin
            if (k > 0) tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (lcd_cs[d] !== (k >= CSH)) begin
                    errors++;
                    $display("FAIL cs_hold dut%0d k=%0d: lcd_cs=%b, required %b", d, k, lcd_cs[d], (k >= CSH));
                end
            end
        end
    endtask

    task automatic run_word(input int p, input logic cod, input logic [15:0] data, input int dly);
        logic [16:0] w;
        set_step(p, 1'b1, cod, data);
        exp_q.push_back({cod, data});
        tick();
        set_step(p, 1'b0, cod, data);
        w = exp_q.pop_front();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (bus_step[d] !== 1'b1 || bus_cod[d] !== w[16] || bus_data[d] !== w[15:0]) begin
                errors++;
                $display("FAIL issue dut%0d: step=%b cod=%b data=%h, required 1 %b %h", d, bus_step[d], bus_cod[d], bus_data[d], w[16], w[15:0]);
            end
        end
        for (int k = 1; k <= dly; k++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (bus_step[d] !== 1'b0 || r0_done[d] !== 1'b0 || r1_done[d] !== 1'b0 || bus_data[d] !== w[15:0]) begin
                    errors++;
                    $display("FAIL wait dut%0d k=%0d: step=%b done=%b%b data=%h, required 0 00 %h",
                             d, k, bus_step[d], r1_done[d], r0_done[d], bus_data[d], w[15:0]);
                end
            end
            if (k == dly) bus_done = 1'b1;
        end
        tick();
        bus_done = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (done_of(d, p) !== 1'b1 || done_of(d, 1 - p) !== 1'b0 || gnt_of(d, p) !== 1'b1 || timeout_err[d] !== 1'b0) begin
                errors++;
                $display("FAIL done dut%0d p%0d: done=%b%b gnt=%b err=%b, required owner done=1 gnt=1 err=0",
                         d, p, r1_done[d], r0_done[d], gnt_of(d, p), timeout_err[d]);
            end
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (r0_done[d] !== 1'b0 || r1_done[d] !== 1'b0 || dbg_state[d] !== ST_GRANTED) begin
                errors++;
                $display("FAIL done_pulse dut%0d: done=%b%b state=%0d, required 00 GRANTED", d, r1_done[d], r0_done[d], dbg_state[d]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_last[d] = 1'b1;
            checks++;
            if ({r0_gnt[d], r1_gnt[d], r0_done[d], r1_done[d], bus_step[d], bus_cod[d], busy[d], timeout_err[d], lcd_cs[d]} !== 9'b000000001
                || bus_data[d] !== 16'h0000 || dbg_state[d] !== ST_IDLE) begin
                errors++;
                $display("FAIL reset dut%0d: gnt=%b%b done=%b%b step=%b cod=%b busy=%b err=%b cs=%b data=%h, required all 0 with cs=1",
                         d, r1_gnt[d], r0_gnt[d], r1_done[d], r0_done[d], bus_step[d], bus_cod[d], busy[d], timeout_err[d], lcd_cs[d], bus_data[d]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_r0_basic();
        acquire(0);
        run_word(0, LCD_CMD, 16'h0022, 5);
        release_port(0);
    endtask

    task automatic test_random_words();
        for (int i = 0; i < 6; i++) begin
            int p = $urandom_range(0, 1);
            int n = $urandom_range(1, 2);
            acquire(p);
            for (int j = 0; j < n; j++)
                run_word(p, 1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(1, TO));
            release_port(p);
        end
    endtask

    task automatic test_round_robin();
        for (int r = 0; r < 6; r++) begin
            logic q0, q1;
            q0 = (r < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            q1 = (r < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            if (!q0 && !q1) begin q0 = 1'b1; q1 = 1'b1; end
            r0_req = q0;
            r1_req = q1;
            tick();
            for (int d = 0; d < 2; d++) begin
                logic w;
                w = pick(q0, q1, d, exp_last[d]);
                exp_last[d] = w;
                checks++;
                if (gnt_of(d, int'(w)) !== 1'b1 || gnt_of(d, 1 - int'(w)) !== 1'b0) begin
                    errors++;
                    $display("FAIL arbitrate dut%0d round%0d req=%b%b: gnt=%b%b, required port %0d", d, r, q1, q0, r1_gnt[d], r0_gnt[d], w);
                end
            end
            r0_req = 1'b0;
            r1_req = 1'b0;
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (r0_gnt[d] !== 1'b0 || r1_gnt[d] !== 1'b0 || dbg_state[d] !== ST_IDLE) begin
                    errors++;
                    $display("FAIL rr_idle dut%0d round%0d: gnt=%b%b state=%0d, required 00 IDLE", d, r, r1_gnt[d], r0_gnt[d], dbg_state[d]);
                end
            end
        end
        repeat (CSH + 1) tick();
    endtask

    task automatic test_lock();
        r1_lock = 1'b1;
        acquire(1);
        run_word(1, LCD_CMD, 16'($urandom), 3);
        r1_req = 1'b0;
        repeat (3) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (r1_gnt[d] !== 1'b1 || dbg_state[d] !== ST_GRANTED) begin
                    errors++;
                    $display("FAIL lock_hold dut%0d: gnt1=%b state=%0d, required 1 GRANTED", d, r1_gnt[d], dbg_state[d]);
                end
            end
        end
        run_word(1, LCD_DATA, 16'hF800, 2);
        release_port(1);
    endtask

    task automatic test_stray();
        logic [15:0] dw;
        acquire(0);
        set_step(1, 1'b1, 1'b1, 16'hBEEF);
        tick();
        set_step(1, 1'b0, 1'b0, 16'h0000);
        repeat (2) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (bus_step[d] !== 1'b0 || dbg_state[d] !== ST_GRANTED || r0_gnt[d] !== 1'b1) begin
                    errors++;
                    $display("FAIL stray_r1_step dut%0d: step=%b state=%0d gnt0=%b, required 0 GRANTED 1", d, bus_step[d], dbg_state[d], r0_gnt[d]);
                end
            end
            tick();
        end
        dw = 16'($urandom);
        set_step(0, 1'b1, 1'b1, dw);
        tick();
        set_step(0, 1'b0, 1'b1, dw);
        tick();
        set_step(0, 1'b1, 1'b0, ~dw);
        tick();
        set_step(0, 1'b0, 1'b0, ~dw);
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (bus_step[d] !== 1'b0 || bus_data[d] !== dw || r0_done[d] !== (k == 0)) begin
                    errors++;
                    $display("FAIL stray_wait_step dut%0d k=%0d: step=%b data=%h done0=%b, required 0 %h %b",
                             d, k, bus_step[d], bus_data[d], r0_done[d], dw, (k == 0));
                end
            end
            tick();
        end
        release_port(0);
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;
        repeat (2) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (r0_done[d] !== 1'b0 || r1_done[d] !== 1'b0 || busy[d] !== 1'b0 || bus_step[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL stray_idle_done dut%0d: done=%b%b busy=%b step=%b, required all 0", d, r1_done[d], r0_done[d], busy[d], bus_step[d]);
                end
            end
            tick();
        end
    endtask

    task automatic test_wd_edge();
        acquire(0);
        run_word(0, LCD_DATA, 16'($urandom), TO);
        release_port(0);
    endtask

    task automatic test_timeout();
        logic [15:0] dw;
        dw = 16'($urandom);
        r0_lock = 1'b1;
        acquire(0);
        set_step(0, 1'b1, 1'b0, dw);
        tick();
        set_step(0, 1'b0, 1'b0, dw);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (bus_step[d] !== 1'b1 || bus_data[d] !== dw) begin
                errors++;
                $display("FAIL to_issue dut%0d: step=%b data=%h, required 1 %h", d, bus_step[d], bus_data[d], dw);
            end
        end
        for (int k = 1; k <= TO; k++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (r0_done[d] !== 1'b0 || timeout_err[d] !== 1'b0 || r0_gnt[d] !== 1'b1) begin
                    errors++;
                    $display("FAIL to_early dut%0d k=%0d: done0=%b err=%b gnt0=%b, required 0 0 1", d, k, r0_done[d], timeout_err[d], r0_gnt[d]);
                end
            end
        end
        tick();
        r0_req = 1'b0;
        r0_lock = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (timeout_err[d] !== 1'b1 || r0_done[d] !== 1'b1 || r0_gnt[d] !== 1'b0 || busy[d] !== 1'b0) begin
                errors++;
                $display("FAIL to_fire dut%0d: err=%b done0=%b gnt0=%b busy=%b, required 1 1 0 0", d, timeout_err[d], r0_done[d], r0_gnt[d], busy[d]);
            end
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (timeout_err[d] !== 1'b1 || r0_done[d] !== 1'b0 || r0_gnt[d] !== 1'b0) begin
                errors++;
                $display("FAIL to_sticky dut%0d: err=%b done0=%b gnt0=%b, required 1 0 0", d, timeout_err[d], r0_done[d], r0_gnt[d]);
            end
        end
        repeat (CSH + 1) tick();
    endtask

    task automatic test_reset_mid_word();
        acquire(1);
        set_step(1, 1'b1, 1'b1, 16'($urandom));
        tick();
        set_step(1, 1'b0, 1'b1, 16'h0000);
        tick();
        #2 rst = 1'b0;
        #1;
        r1_req = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_last[d] = 1'b1;
            checks++;
            if (lcd_cs[d] !== 1'b1 || r0_gnt[d] !== 1'b0 || r1_gnt[d] !== 1'b0 || r0_done[d] !== 1'b0 || r1_done[d] !== 1'b0
                || bus_step[d] !== 1'b0 || timeout_err[d] !== 1'b0 || busy[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid dut%0d: cs=%b gnt=%b%b done=%b%b step=%b err=%b busy=%b, required cs=1 rest 0",
                         d, lcd_cs[d], r1_gnt[d], r0_gnt[d], r1_done[d], r0_done[d], bus_step[d], timeout_err[d], busy[d]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        bus_done = 1'b1;
        tick();
        bus_done = 1'b0;
        repeat (4) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (r0_done[d] !== 1'b0 || r1_done[d] !== 1'b0 || busy[d] !== 1'b0 || lcd_cs[d] !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_after dut%0d: done=%b%b busy=%b cs=%b, required 00 0 1", d, r1_done[d], r0_done[d], busy[d], lcd_cs[d]);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_r0_basic();
        test_random_words();
        test_round_robin();
        test_lock();
        test_stray();
        test_wd_edge();
        test_timeout();
        test_reset_mid_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
